// File: rtl/mul_pkg.sv
// Shared definitions for the multiply/accumulate stage: op encodings, FSM states, byte width.
package mul_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] MUL_OP_MUL = 2'b00;
  localparam logic [1:0] MUL_OP_MAC = 2'b01;
  localparam logic [1:0] MUL_OP_CLR = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StOutLo,
    StOutHi
  } state_e;

endpackage

// File: rtl/mul_array8x8.sv
// Existing 8x8 unsigned combinational array multiplier (shift-and-add of partial products).
module mul_array8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p + ({8'd0, a} << i);
    end
  end

endmodule

// File: rtl/mul_sign_corr.sv
// Turns an unsigned 8x8 product into the two's-complement product when op_signed is set.
module mul_sign_corr
  import mul_pkg::*;
(
  input  logic [BYTE_W-1:0]   a,
  input  logic [BYTE_W-1:0]   b,
  input  logic [2*BYTE_W-1:0] prod,
  input  logic                op_signed,
  output logic [2*BYTE_W-1:0] p
);

  logic [2*BYTE_W-1:0] corr_a;
  logic [2*BYTE_W-1:0] corr_b;

  // A negative operand contributes an extra 2^8 * (other operand) in the unsigned product.
  always_comb begin
    corr_a = (op_signed && a[BYTE_W-1]) ? {b, {BYTE_W{1'b0}}} : '0;
    corr_b = (op_signed && b[BYTE_W-1]) ? {a, {BYTE_W{1'b0}}} : '0;
    p      = prod - corr_a - corr_b;
  end

endmodule

// File: rtl/mul_acc_unit.sv
// Sequential multiply / multiply-accumulate stage returning a 16-bit result as two bytes.
// Define MUL_ACC_MAC_EN to build the accumulator, acc_ovf and the MAC/CLR modes.
module mul_acc_unit
  import mul_pkg::*;
#(
  parameter int unsigned ACC_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] op_a,
  input  logic [BYTE_W-1:0] op_b,
  input  logic              op_signed,
  input  logic [1:0]        op_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_last,
  output logic              acc_ovf,
  output logic              busy
);

  if (ACC_W < 16 || ACC_W > 32) begin : g_bad_acc_w
    $error("mul_acc_unit: ACC_W must be in 16..32");
  end

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   a_q, b_q;
  logic                signed_q;
  logic [1:0]          mode_q;
  logic [2*BYTE_W-1:0] result_q;
  logic [2*BYTE_W-1:0] prod_u;
  logic [2*BYTE_W-1:0] prod;
  logic                is_clr;

  mul_array8x8 u_array (
    .a (a_q),
    .b (b_q),
    .p (prod_u)
  );

  mul_sign_corr u_sign_corr (
    .a         (a_q),
    .b         (b_q),
    .prod      (prod_u),
    .op_signed (signed_q),
    .p         (prod)
  );

  assign is_clr = (mode_q == MUL_OP_CLR);

`ifdef MUL_ACC_MAC_EN
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W:0]   sum;
  logic             ovf_q;
  logic             ovf_now;
  logic             is_mac;

  assign is_mac = (mode_q == MUL_OP_MAC);

  always_comb begin
    p_ext    = signed_q ? ACC_W'($signed(prod)) : ACC_W'(prod);
    sum      = {1'b0, acc_q} + {1'b0, p_ext};
    acc_next = sum[ACC_W-1:0];
    // Signed overflow: like-signed addends yield a result of the opposite sign.
    if (signed_q) begin
      ovf_now = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (acc_next[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      ovf_now = sum[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (state_q == StCalc) begin
      if (is_clr) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else if (is_mac) begin
        acc_q <= acc_next;
        if (ovf_now) ovf_q <= 1'b1;
      end
    end
  end

  assign acc_ovf = ovf_q;
`else
  assign acc_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      mode_q   <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && in_valid) begin
        a_q      <= op_a;
        b_q      <= op_b;
        signed_q <= op_signed;
        mode_q   <= op_mode;
      end
      if (state_q == StCalc && !is_clr) begin
`ifdef MUL_ACC_MAC_EN
        result_q <= is_mac ? acc_next[2*BYTE_W-1:0] : prod;
`else
        result_q <= prod;
`endif
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    out_byte  = '0;
    out_last  = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = StCalc;
      end
      StCalc: begin
        state_d = is_clr ? StIdle : StOutLo;
      end
      StOutLo: begin
        out_valid = 1'b1;
        out_byte  = result_q[BYTE_W-1:0];
        if (out_ready) state_d = StOutHi;
      end
      StOutHi: begin
        out_valid = 1'b1;
        out_byte  = result_q[2*BYTE_W-1:BYTE_W];
        out_last  = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/mul_acc_unit.md
# mul_acc_unit

Sequential multiply/multiply-accumulate stage of the 8-bit CPU ALU, wrapped around the team's existing 8x8 unsigned combinational array multiplier. It accepts an operand pair over a valid/ready handshake and registers the operands so the array multiplier sees stable inputs for one full cycle. It applies signed correction and optionally accumulates the result. The 16-bit result is returned to the 8-bit datapath as two bytes, low byte first.

## Interface
- ACC_W, 20: accumulator width in bits. Legal range 16..32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request; high only in IDLE
- op_a  in  8  multiplicand
- op_b  in  8  multiplier
- op_signed  in  1  1 = two's-complement operands, 0 = unsigned
- op_mode  in  2  operation: 00 MUL, 01 MAC, 10 CLR, 11 reserved (treated as MUL)
- out_valid  out  1  result byte valid
- out_ready  in  1  consumer accepts the byte
- out_byte  out  8  result byte
- out_last  out  1  marks the high byte
- acc_ovf  out  1  sticky accumulator-overflow flag
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states are IDLE, CALC, OUT_LO, OUT_HI.
- IDLE:
  - Drives in_ready=1.
  - On in_valid&&in_ready, registers op_a, op_b, op_signed and op_mode, then moves to CALC.
- CALC:
  - The array multiplier is driven from the registered operands.
  - Unsigned: p = a*b.
  - Signed: p = a*b − (a[7] ? b<<8 : 0) − (b[7] ? a<<8 : 0), taken mod 2^16.
  - MUL: p is registered into the result register.
  - MAC: acc ← acc + ext(p), where ext is sign-extension if op_signed, otherwise zero-extension. The result register takes acc_next[15:0].
  - CLR: acc ← 0 and acc_ovf ← 0. The FSM returns directly to IDLE and produces no output bytes.
  - All other modes go to OUT_LO.
- OUT_LO: out_valid=1, out_byte=result[7:0], out_last=0. Advances to OUT_HI on out_ready.
- OUT_HI: out_valid=1, out_byte=result[15:8], out_last=1. Returns to IDLE on out_ready.
- Accumulator arithmetic:
  - acc is ACC_W bits and wraps on overflow.
  - acc_ovf is set on signed overflow when op_signed=1, and on unsigned carry-out of ACC_W when op_signed=0.
  - acc_ovf stays set until CLR or reset.
- Reserved op_mode 11 behaves exactly as MUL.

## Timing
- Reset values, applied asynchronously:
  - State is IDLE, so in_ready=1 and busy=0.
  - out_valid=0, out_last=0, out_byte=0.
  - acc=0, acc_ovf=0, all operand and result registers 0.
- Latency is accept at cycle 0, low byte valid at cycle 2, high byte at cycle 3 when out_ready is held high.
- Minimum issue interval is 4 cycles for MUL/MAC and 2 cycles for CLR.
- in_ready=0 from the accept edge until OUT_HI completes, so requests never overlap.
- out_byte and out_last hold stable while out_valid=1 and out_ready=0.
- in_valid has no effect outside IDLE.
- Reset asserted mid-operation aborts the operation:
  - out_valid drops immediately.
  - acc and acc_ovf clear.
  - The unit accepts a request on the first edge after rst_n rises.

## Configuration
- MUL_ACC_MAC_EN defined:
  - The accumulator, acc_ovf, and the MAC and CLR modes are present.
- MUL_ACC_MAC_EN undefined:
  - No accumulator is built and acc_ovf is tied to 0.
  - MAC decodes as MUL.
  - CLR completes as a 2-cycle no-op with no output bytes.

## Structure
- Shared package mul_pkg holds:
  - The op_mode encodings: MUL_OP_MUL, MUL_OP_MAC, MUL_OP_CLR.
  - The FSM state typedef.
  - The byte-width constant (8).
- The existing 8x8 unsigned array multiplier is instantiated unchanged.
- One new sub-module, mul_sign_corr, is natural: combinational, taking a, b, the unsigned product and op_signed, and producing the corrected 16-bit p.

## Test plan
- Unsigned MUL, 0xFF×0xFF → bytes 0x01 then 0xFE, out_last=1 on the second byte, out_valid at cycle 2.
- Signed MUL, 0x80×0x7F (−128×127) → 0xC080, bytes 0x80 then 0xC0. Signed 0xFF×0xFF → 0x0001.
- Backpressure: out_ready low for 3 cycles in OUT_LO → out_byte held at the low byte, in_ready=0 throughout, and a new in_valid is ignored.
- MAC: CLR, then signed MAC of 0xFE×0x03 twice → acc=0xFFFF4 (ACC_W=20), final bytes 0xF4 then 0xFF, acc_ovf=0.
- Overflow: CLR, then unsigned MAC of 0xFF×0xFF issued 17 times → acc_ovf rises after the 17th (1105425 > 2^20−1), acc=0x0DE11. A following CLR clears acc_ovf.
- Reset mid-operation: assert rst_n in OUT_HI → out_valid=0 and acc=0 immediately. After release, in_ready=1 and a MUL of 0x02×0x03 returns 0x06 then 0x00.
